slice_sequencer: RTL and testbench

Parametrised per-slice sequencer for the ProRes encoder pipeline. It replaces the free-running sequence counter with a slice-triggered, restartable counter. From a latched block count it generates registered enable windows and local counters for the DCT, DC-VLC and AC-VLC stages. It sits between the slice scheduler (slice_start/slice_abort) and the entropy coders, and reports busy/done so slices can be issued back to back.

---
 rtl/slice_sequencer.sv | 126 ++++++++++++
 tb/tb_slice_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/slice_sequencer.sv
// Slice-triggered sequencer: from a latched block count it produces registered
// DCT / DC-VLC / AC-VLC enable windows and local counters, plus busy/done status.
module slice_sequencer #(
   parameter int CNT_W        = 16,
   parameter int BN_W         = 8,
   parameter int DCT_TIME     = 12,
   parameter int DC_VLC_TIME  = 44,
   parameter int DC_TAIL      = 6,
   parameter int AC_PER_BLOCK = 63,
   parameter int AC_TAIL      = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             slice_start,
   input  logic             slice_abort,
   input  logic [BN_W-1:0]  block_num,
   output logic             busy,
   output logic             done,
   output logic             start_err,
   output logic [CNT_W-1:0] seq_cnt,
   output logic             dct_en,
   output logic             dc_vlc_en,
   output logic [CNT_W-1:0] dc_vlc_cnt,
   output logic             ac_vlc_en,
   output logic [CNT_W-1:0] ac_vlc_cnt
);

   localparam logic [CNT_W-1:0] K_DCT  = CNT_W'(DCT_TIME);
   localparam logic [CNT_W-1:0] K_DCV  = CNT_W'(DC_VLC_TIME);
   localparam logic [CNT_W-1:0] K_DCT_TAIL = CNT_W'(DC_TAIL);
   localparam logic [CNT_W-1:0] K_ACPB = CNT_W'(AC_PER_BLOCK);
   localparam logic [CNT_W-1:0] K_ACT  = CNT_W'(AC_TAIL);
   localparam logic [CNT_W-1:0] K_ONE  = CNT_W'(1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [BN_W-1:0]  bn;
   logic [CNT_W-1:0] dc_end;
   logic [CNT_W-1:0] ac_start;
   logic [CNT_W-1:0] done_t;

   // Bounds for a slice about to be accepted, derived from the live block_num.
   logic [CNT_W-1:0] bn_in, dct_lim_in, dc_end_in, ac_start_in, done_t_in;
   // Bounds of the running slice; done_t doubles as the exclusive AC end.
   logic [CNT_W-1:0] dct_lim, dc_start, nt;
   logic             dct_n, dc_n, ac_n, done_n;
   logic             accept, clear;

   always_comb begin
      bn_in       = CNT_W'(block_num);
      dct_lim_in  = K_DCT + bn_in;
      dc_end_in   = dct_lim_in + bn_in + K_DCT_TAIL;
      ac_start_in = dct_lim_in + K_DCV + K_ONE;
      done_t_in   = ac_start_in + K_ACPB * bn_in + K_ACT;

      dct_lim  = K_DCT + CNT_W'(bn);
      dc_start = dct_lim + K_ONE;
      nt       = seq_cnt + K_ONE;
      dct_n    = (nt < dct_lim);
      dc_n     = (nt >= dc_start) && (nt <= dc_end);
      ac_n     = (nt >= ac_start) && (nt < done_t);
      done_n   = (nt == done_t);

      // done is only ever high in RUN, so it marks the back-to-back window.
      accept = slice_start && ((state == IDLE) || (done && !slice_abort));
      clear  = (state == RUN) && (slice_abort || (done && !slice_start));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         bn         <= '0;
         dc_end     <= '0;
         ac_start   <= '0;
         done_t     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         start_err  <= 1'b0;
         seq_cnt    <= '0;
         dct_en     <= 1'b0;
         dc_vlc_en  <= 1'b0;
         dc_vlc_cnt <= '0;
         ac_vlc_en  <= 1'b0;
         ac_vlc_cnt <= '0;
      end else if (accept) begin
         state      <= RUN;
         bn         <= block_num;
         dc_end     <= dc_end_in;
         ac_start   <= ac_start_in;
         done_t     <= done_t_in;
         busy       <= 1'b1;
         done       <= 1'b0;
         start_err  <= 1'b0;
         seq_cnt    <= '0;
         dct_en     <= (dct_lim_in != '0);
         dc_vlc_en  <= 1'b0;
         dc_vlc_cnt <= '0;
         ac_vlc_en  <= 1'b0;
         ac_vlc_cnt <= '0;
      end else if (clear || (state == IDLE)) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         start_err  <= 1'b0;
         seq_cnt    <= '0;
         dct_en     <= 1'b0;
         dc_vlc_en  <= 1'b0;
         dc_vlc_cnt <= '0;
         ac_vlc_en  <= 1'b0;
         ac_vlc_cnt <= '0;
      end else begin
         // Look-ahead: every output is computed for the next seq_cnt value.
         busy       <= 1'b1;
         done       <= done_n;
         start_err  <= slice_start;
         seq_cnt    <= nt;
         dct_en     <= dct_n;
         dc_vlc_en  <= dc_n;
         dc_vlc_cnt <= dc_n ? (nt - dc_start) : '0;
         ac_vlc_en  <= ac_n;
         ac_vlc_cnt <= ac_n ? (nt - ac_start) : '0;
      end
   end

endmodule

// File: tb/tb_slice_sequencer.sv
// Directed bench for slice_sequencer: per-cycle window checks against
// hand-computed window bounds for several block counts and control events.
module tb_slice_sequencer;

   logic        clock;
   logic        reset_n;
   logic        slice_start;
   logic        slice_abort;
   logic [7:0]  block_num;
   logic        busy, done, start_err, dct_en, dc_vlc_en, ac_vlc_en;
   logic [15:0] seq_cnt, dc_vlc_cnt, ac_vlc_cnt;

   int checks = 0;
   int errors = 0;

   slice_sequencer dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .slice_start (slice_start),
      .slice_abort (slice_abort),
      .block_num   (block_num),
      .busy        (busy),
      .done        (done),
      .start_err   (start_err),
      .seq_cnt     (seq_cnt),
      .dct_en      (dct_en),
      .dc_vlc_en   (dc_vlc_en),
      .dc_vlc_cnt  (dc_vlc_cnt),
      .ac_vlc_en   (ac_vlc_en),
      .ac_vlc_cnt  (ac_vlc_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},  -1, 32'(busy), 0);
      check({tag, "_done"},  -1, 32'(done), 0);
      check({tag, "_err"},   -1, 32'(start_err), 0);
      check({tag, "_seq"},   -1, 32'(seq_cnt), 0);
      check({tag, "_dct"},   -1, 32'(dct_en), 0);
      check({tag, "_dc"},    -1, 32'(dc_vlc_en), 0);
      check({tag, "_dccnt"}, -1, 32'(dc_vlc_cnt), 0);
      check({tag, "_ac"},    -1, 32'(ac_vlc_en), 0);
      check({tag, "_accnt"}, -1, 32'(ac_vlc_cnt), 0);
   endtask

   // dct_n: number of DCT cycles; dcs..dce, acs..ace inclusive windows; dn: done cycle.
   task automatic check_cycle(input int t, input int dct_n, input int dcs, input int dce,
                              input int acs, input int ace, input int dn, input logic exp_err);
      logic dc_on, ac_on;
      dc_on = (t >= dcs) && (t <= dce);
      ac_on = (t >= acs) && (t <= ace);
      check("busy",  t, 32'(busy), 1);
      check("seq",   t, 32'(seq_cnt), 32'(t));
      check("dct",   t, 32'(dct_en), 32'(t < dct_n));
      check("dc",    t, 32'(dc_vlc_en), 32'(dc_on));
      check("dccnt", t, 32'(dc_vlc_cnt), dc_on ? 32'(t - dcs) : 0);
      check("ac",    t, 32'(ac_vlc_en), 32'(ac_on));
      check("accnt", t, 32'(ac_vlc_cnt), ac_on ? 32'(t - acs) : 0);
      check("done",  t, 32'(done), 32'(t == dn));
      check("err",   t, 32'(start_err), 32'(exp_err));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic start(input logic [7:0] bn, input logic ab);
      slice_start = 1'b1;
      slice_abort = ab;
      block_num   = bn;
      step();
      slice_start = 1'b0;
      slice_abort = 1'b0;
   endtask

   // ev_kind: 0 none, 1 stray start, 2 abort (with start), 3 back-to-back start.
   task automatic run_slice(input int dct_n, input int dcs, input int dce, input int acs,
                            input int ace, input int dn, input int ev_t, input int ev_kind,
                            input logic [7:0] ev_bn);
      for (int t = 0; t <= dn; t++) begin
         check_cycle(t, dct_n, dcs, dce, acs, ace, dn, (ev_kind == 1) && (t == ev_t + 1));
         if ((ev_kind != 0) && (t == ev_t)) begin
            slice_start = 1'b1;
            slice_abort = (ev_kind == 2);
            block_num   = ev_bn;
         end
         step();
         slice_start = 1'b0;
         slice_abort = 1'b0;
         if ((ev_kind == 2) && (t == ev_t)) return;
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      slice_start = 1'b0;
      slice_abort = 1'b0;
      block_num   = 8'd0;
      #12;
      check_idle("reset");
      step();
      reset_n = 1'b1;
      step();
      check_idle("post_reset");

      // Abort while idle is ignored.
      slice_abort = 1'b1;
      step();
      slice_abort = 1'b0;
      check_idle("idle_abort");

      // bn=8: windows 0..19, 21..34, 65..574, done 575.
      start(8'd8, 1'b0);
      run_slice(20, 21, 34, 65, 574, 575, 0, 0, 8'd0);
      check_idle("end_bn8");

      // bn=0: windows 0..11, 13..18, 57..62, done 63.
      start(8'd0, 1'b0);
      run_slice(12, 13, 18, 57, 62, 63, 0, 0, 8'd0);
      check_idle("end_bn0");

      // bn=2 then back-to-back bn=1 (windows 0..12, 14..20, 58..126, done 127).
      start(8'd2, 1'b0);
      run_slice(14, 15, 22, 59, 190, 191, 191, 3, 8'd1);
      run_slice(13, 14, 20, 58, 126, 127, 0, 0, 8'd0);
      check_idle("end_b2b");

      // Stray start at t=100 with a different block_num: start_err at t=101 only.
      start(8'd8, 1'b0);
      run_slice(20, 21, 34, 65, 574, 575, 100, 1, 8'd3);
      check_idle("end_stray");

      // Abort (with simultaneous start) at t=30, then a start with abort held in idle.
      start(8'd8, 1'b0);
      run_slice(20, 21, 34, 65, 574, 575, 30, 2, 8'd5);
      check_idle("abort");
      start(8'd0, 1'b1);
      run_slice(12, 13, 18, 57, 62, 63, 0, 0, 8'd0);
      check_idle("end_after_abort");

      // bn=255: DC 268..528 overlaps AC 312..16382, done 16383.
      start(8'd255, 1'b0);
      run_slice(267, 268, 528, 312, 16382, 16383, 0, 0, 8'd0);
      check_idle("end_bn255");

      // Asynchronous reset at t=200 clears outputs immediately.
      start(8'd8, 1'b0);
      for (int t = 0; t <= 200; t++) begin
         check_cycle(t, 20, 21, 34, 65, 574, 575, 1'b0);
         if (t < 200) step();
      end
      #2;
      reset_n = 1'b0;
      #1;
      check_idle("async_reset");
      step();
      reset_n = 1'b1;
      step();
      check_idle("after_async_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
